// File: rtl/atanh_search_4bit_pkg.sv
// Shared types, the forward tanh table and helpers for the 4-bit atanh search.
package atanh_pkg;

  localparam int CODE_W = 4;

  // F(k) = round(15*tanh(k/4)), k = 0..15
  localparam logic [CODE_W-1:0] TANH4_FWD [16] = '{
    4'd0,  4'd4,  4'd7,  4'd10, 4'd11, 4'd13, 4'd14, 4'd14,
    4'd14, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [CODE_W-1:0] abs_diff4(input logic [CODE_W-1:0] a,
                                                  input logic [CODE_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/atanh_search_4bit_if.sv
// Request/result handshake bundle of the atanh search block.
interface atanh_search_4bit_if;
  import atanh_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] y_in;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] x_out;
  logic [CODE_W-1:0] err_out;
  logic              busy;

  modport master (
    output in_valid, y_in, out_ready,
    input  in_ready, out_valid, x_out, err_out, busy
  );

  modport slave (
    input  in_valid, y_in, out_ready,
    output in_ready, out_valid, x_out, err_out, busy
  );

endinterface

// File: rtl/atanh_search_4bit_tanh_q22_lut.sv
// Combinational forward tanh lookup F(idx); approximate forward circuits can replace this body.
module tanh_q22_lut
  import atanh_pkg::*;
(
  input  logic [CODE_W-1:0] idx,
  output logic [CODE_W-1:0] f
);

  assign f = TANH4_FWD[idx];

endmodule

// File: rtl/atanh_search_4bit.sv
// Inverse 4-bit tanh: scans candidate x codes one per cycle and returns argmin |F(x)-y|.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// SEARCH | evaluating candidate idx, one per cycle
// DONE   | result presented on x_out/err_out until out_ready
module atanh_search_4bit
  import atanh_pkg::*;
#(
  parameter bit          EARLY_EXIT = 1'b1,
  parameter int unsigned LAST_IDX   = 15
)
(
  input  logic              clk,
  input  logic              rst,
  atanh_search_4bit_if.slave bus
);

  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(LAST_IDX);

  state_t            state, state_nxt;
  logic [CODE_W-1:0] idx;
  logic [CODE_W-1:0] y_reg;
  logic [CODE_W-1:0] best_x, best_err;
  logic [CODE_W-1:0] x_q, err_q;
  logic [CODE_W-1:0] f_idx;
  logic [CODE_W-1:0] err;
  logic [CODE_W-1:0] cand_x, cand_err;
  logic              better;
  logic              stop;

  tanh_q22_lut u_lut (
    .idx (idx),
    .f   (f_idx)
  );

  // Strict compare keeps the earlier (smaller) x on ties.
  always_comb begin
    err      = abs_diff4(f_idx, y_reg);
    better   = (err < best_err);
    cand_x   = better ? idx : best_x;
    cand_err = better ? err : best_err;
    stop     = (EARLY_EXIT && (err == '0)) || (idx == LAST_CODE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SEARCH;
      SEARCH:  if (stop)         state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Result registers are loaded only on the terminating candidate so the outputs
  // keep their previous values while a new search runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      y_reg    <= '0;
      best_x   <= '0;
      best_err <= '0;
      x_q      <= '0;
      err_q    <= '0;
    end else begin
      if ((state == IDLE) && bus.in_valid) begin
        y_reg    <= bus.y_in;
        idx      <= '0;
        best_x   <= '0;
        best_err <= 4'hF;
      end else if (state == SEARCH) begin
        best_x   <= cand_x;
        best_err <= cand_err;
        if (stop) begin
          x_q   <= cand_x;
          err_q <= cand_err;
        end else begin
          idx <= idx + 4'd1;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.x_out     = x_q;
    bus.err_out   = err_q;
  end

endmodule

// File: tb/tb_atanh_search_4bit.sv
// Bench for atanh_search_4bit: directed and randomized requests against an argmin model.
module tb_atanh_search_4bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  atanh_search_4bit_if a_if ();
  atanh_search_4bit_if b_if ();

  atanh_search_4bit #(.EARLY_EXIT(1'b1), .LAST_IDX(15)) dut_a (
    .clk (clk), .rst (rst), .bus (a_if)
  );

  atanh_search_4bit #(.EARLY_EXIT(1'b0), .LAST_IDX(15)) dut_b (
    .clk (clk), .rst (rst), .bus (b_if)
  );

  // Reference: brute-force argmin over the tanh table, first minimum wins.
  function automatic void ref_atanh(input int y, output int bx, output int be);
    int f [16] = '{0, 4, 7, 10, 11, 13, 14, 14, 14, 15, 15, 15, 15, 15, 15, 15};
    bx = 0;
    be = 1000;
    for (int k = 0; k < 16; k++) begin
      int d;
      d = (f[k] > y) ? f[k] - y : y - f[k];
      if (d < be) begin
        be = d;
        bx = k;
      end
    end
  endfunction

  function automatic int ref_latency(input int bx, input int be, input bit early);
    return (early && be == 0) ? bx + 1 : 16;
  endfunction

  // Issues y to both DUTs together, returns each result and its latency in edges after E0.
  task automatic run_req(input logic [3:0] y,
                         output logic [3:0] xa, output logic [3:0] ea, output int la,
                         output logic [3:0] xb, output logic [3:0] eb, output int lb);
    xa = 'x; ea = 'x; xb = 'x; eb = 'x; la = -1; lb = -1;
    @(negedge clk);
    a_if.y_in = y; b_if.y_in = y;
    a_if.in_valid = 1'b1; b_if.in_valid = 1'b1;
    a_if.out_ready = 1'b0; b_if.out_ready = 1'b0;
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b0; b_if.in_valid = 1'b0;
    a_if.y_in = 4'($urandom); b_if.y_in = 4'($urandom);
    for (int n = 1; n <= 40 && (la < 0 || lb < 0); n++) begin
      @(posedge clk);
      #1;
      if (la < 0 && a_if.out_valid) begin la = n; xa = a_if.x_out; ea = a_if.err_out; end
      if (lb < 0 && b_if.out_valid) begin lb = n; xb = b_if.x_out; eb = b_if.err_out; end
    end
    @(negedge clk);
    a_if.out_ready = 1'b1; b_if.out_ready = 1'b1;
    @(negedge clk);
    a_if.out_ready = 1'b0; b_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0 || a_if.busy !== 1'b0 ||
        a_if.x_out !== 4'd0 || a_if.err_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b x=%0d err=%0d, want 1 0 0 0 0",
               a_if.in_ready, a_if.out_valid, a_if.busy, a_if.x_out, a_if.err_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_exact();
    logic [3:0] ys [3] = '{4'd0, 4'd7, 4'd10};
    logic [3:0] xa, ea, xb, eb;
    int la, lb, bx, be;
    foreach (ys[i]) begin
      run_req(ys[i], xa, ea, la, xb, eb, lb);
      ref_atanh(ys[i], bx, be);
      checks++;
      if (xa !== 4'(bx) || ea !== 4'(be) || la != ref_latency(bx, be, 1'b1)) begin
        errors++;
        $display("FAIL exact_y%0d: x=%0d err=%0d lat=%0d, want x=%0d err=%0d lat=%0d",
                 ys[i], xa, ea, la, bx, be, ref_latency(bx, be, 1'b1));
      end
      checks++;
      if (xb !== 4'(bx) || eb !== 4'(be) || lb != 16) begin
        errors++;
        $display("FAIL exact_full_y%0d: x=%0d err=%0d lat=%0d, want x=%0d err=%0d lat=16",
                 ys[i], xb, eb, lb, bx, be);
      end
    end
  endtask

  task automatic test_ties();
    logic [3:0] ys [3] = '{4'd12, 4'd5, 4'd2};
    logic [3:0] xa, ea, xb, eb;
    int la, lb, bx, be;
    foreach (ys[i]) begin
      run_req(ys[i], xa, ea, la, xb, eb, lb);
      ref_atanh(ys[i], bx, be);
      checks++;
      if (xa !== 4'(bx) || ea !== 4'(be) || la != 16) begin
        errors++;
        $display("FAIL tie_y%0d: x=%0d err=%0d lat=%0d, want x=%0d err=%0d lat=16",
                 ys[i], xa, ea, la, bx, be);
      end
    end
    checks++;
    run_req(4'd12, xa, ea, la, xb, eb, lb);
    if (xa !== 4'd4 || ea !== 4'd1) begin
      errors++;
      $display("FAIL tie_y12_const: x=%0d err=%0d, want x=4 err=1", xa, ea);
    end
  endtask

  task automatic test_plateau();
    logic [3:0] ys [2] = '{4'd14, 4'd15};
    int         xs [2] = '{6, 9};
    int         ls [2] = '{7, 10};
    logic [3:0] xa, ea, xb, eb;
    int la, lb;
    foreach (ys[i]) begin
      run_req(ys[i], xa, ea, la, xb, eb, lb);
      checks++;
      if (xa !== 4'(xs[i]) || ea !== 4'd0 || la != ls[i]) begin
        errors++;
        $display("FAIL plateau_y%0d: x=%0d err=%0d lat=%0d, want x=%0d err=0 lat=%0d",
                 ys[i], xa, ea, la, xs[i], ls[i]);
      end
      checks++;
      if (xb !== 4'(xs[i]) || eb !== 4'd0 || lb != 16) begin
        errors++;
        $display("FAIL plateau_full_y%0d: x=%0d err=%0d lat=%0d, want x=%0d err=0 lat=16",
                 ys[i], xb, eb, lb, xs[i]);
      end
    end
  endtask

  task automatic test_reset_mid_search();
    bit saw_valid = 1'b0;
    @(negedge clk);
    a_if.y_in = 4'd12; a_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.in_ready !== 1'b1 || a_if.busy !== 1'b0 || a_if.x_out !== 4'd0 ||
        a_if.err_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_search: rdy=%b busy=%b x=%0d err=%0d, want 1 0 0 0",
               a_if.in_ready, a_if.busy, a_if.x_out, a_if.err_out);
    end
    for (int n = 0; n < 20; n++) begin
      if (a_if.out_valid !== 1'b0) saw_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL reset_discard: out_valid seen=1, want 0");
    end
  endtask

  task automatic test_back_pressure();
    bit   unstable = 1'b0;
    bit   rdy_seen = 1'b0;
    int   guard = 0;
    @(negedge clk);
    a_if.y_in = 4'd5; a_if.in_valid = 1'b1; a_if.out_ready = 1'b0;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    while (!a_if.out_valid && guard < 40) begin @(negedge clk); guard++; end
    checks++;
    if (!a_if.out_valid) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b, want 1 within 40 cycles", a_if.out_valid);
    end
    for (int n = 0; n < 20; n++) begin
      a_if.in_valid = 1'($urandom_range(0, 1));
      a_if.y_in = 4'($urandom);
      if (a_if.out_valid !== 1'b1 || a_if.x_out !== 4'd1 || a_if.err_out !== 4'd1) unstable = 1'b1;
      if (a_if.in_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
    end
    a_if.in_valid = 1'b0;
    checks++;
    if (unstable || rdy_seen) begin
      errors++;
      $display("FAIL bp_hold: unstable=%b in_ready_seen=%b, want 0 0", unstable, rdy_seen);
    end
    a_if.out_ready = 1'b1;
    #1;
    checks++;
    if (a_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_passthru: in_ready=%b, want 0", a_if.in_ready);
    end
    @(negedge clk);
    a_if.out_ready = 1'b0;
    checks++;
    if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", a_if.in_ready, a_if.out_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (a_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored_valid: busy=%b, want 0", a_if.busy);
    end
  endtask

  task automatic test_random();
    logic [3:0] order [16];
    logic [3:0] exp_q [$];
    int got = 0;
    for (int i = 0; i < 16; i++) order[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      int j;
      logic [3:0] t;
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          int guard = 0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a_if.in_valid = 1'b1;
          a_if.y_in = order[i];
          while (!a_if.in_ready && guard < 200) begin @(negedge clk); guard++; end
          if (!a_if.in_ready) begin
            errors++;
            $display("FAIL rand_accept_timeout: y=%0d in_ready=0, want 1", order[i]);
          end else begin
            exp_q.push_back(order[i]);
          end
          @(negedge clk);
          a_if.in_valid = 1'b0;
          a_if.y_in = 4'($urandom);
        end
      end
      begin
        int cyc = 0;
        while (got < 16 && cyc < 3000) begin
          a_if.out_ready = 1'($urandom_range(0, 1));
          if (a_if.out_valid && a_if.out_ready) begin
            int bx, be;
            logic [3:0] y;
            got++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rand_duplicate: extra result x=%0d, want none", a_if.x_out);
            end else begin
              y = exp_q.pop_front();
              ref_atanh(y, bx, be);
              if (a_if.x_out !== 4'(bx) || a_if.err_out !== 4'(be)) begin
                errors++;
                $display("FAIL rand_y%0d: x=%0d err=%0d, want x=%0d err=%0d",
                         y, a_if.x_out, a_if.err_out, bx, be);
              end
            end
          end
          @(negedge clk);
          cyc++;
        end
        a_if.out_ready = 1'b0;
      end
    join
    checks++;
    if (got != 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count: results=%0d pending=%0d, want 16 0", got, exp_q.size());
    end
  endtask

  initial begin
    a_if.in_valid = 1'b0; a_if.y_in = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.y_in = '0; b_if.out_ready = 1'b0;
    test_reset();
    test_exact();
    test_ties();
    test_plateau();
    test_reset_mid_search();
    test_back_pressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
